// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counting timer with one-cycle terminal-count pulse
// Optional build macro DOWN_TIMER_RELOAD_EN: periodic mode that reloads the count at terminal.
module down_timer #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] value,
    input  logic         start,
    input  logic         pause,
    input  logic         stop,
    output logic [N-1:0] cnt,
    output logic         busy,
    output logic         tc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         tc_q;
    logic         tc_d;

`ifdef DOWN_TIMER_RELOAD_EN
    logic [N-1:0] reload_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= value;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    // Priority: load, then stop, then start/pause/count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        if (load) begin
            cnt_d   = value;
            state_d = IDLE;
        end else if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cnt_q != '0) begin
                            state_d = RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (cnt_q > ONE) begin
                        cnt_d   = cnt_q - ONE;
                        state_d = RUN;
                    end else if (cnt_q == ONE) begin
                        tc_d = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
                        cnt_d   = reload_q;
                        state_d = RUN;
`else
                        cnt_d   = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        // A zero count cannot advance; fall back to idle silently.
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign busy = (state_q != IDLE);
    assign tc   = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - scoreboard bench for down_timer (N=4), both reload and non-reload builds
module tb_down_timer;

    localparam int N = 4;
`ifdef DOWN_TIMER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         load;
    logic [N-1:0] value;
    logic         start;
    logic         pause;
    logic         stop;
    logic [N-1:0] cnt;
    logic         busy;
    logic         tc;

    typedef struct {
        string    tag;
        int       cnt;
        int       busy;
        int       tc;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    down_timer #(.N(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .value   (value),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
        .cnt     (cnt),
        .busy    (busy),
        .tc      (tc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
    task automatic step(input string tag, input logic ld, input int val, input logic st,
                        input logic ps, input logic sp, input int e_cnt, input int e_busy,
                        input int e_tc);
        exp_t e;
        load  = ld;
        value = N'(val);
        start = st;
        pause = ps;
        stop  = sp;
        e.tag = tag; e.cnt = e_cnt; e.busy = e_busy; e.tc = e_tc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_cnt"},  int'(cnt),  e.cnt);
            check({e.tag, "_busy"}, int'(busy), e.busy);
            check({e.tag, "_tc"},   int'(tc),   e.tc);
        end
    endtask

    task automatic idle(input string tag, input int e_cnt, input int e_busy, input int e_tc);
        step(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0, e_cnt, e_busy, e_tc);
    endtask

    // Terminal edge: cnt and busy depend on whether the build reloads.
    task automatic terminal(input string tag, input int v);
        idle(tag, RELOAD ? v : 0, RELOAD ? 1 : 0, 1);
        if (RELOAD) step({tag, "_stop"}, 1'b0, 0, 1'b0, 1'b0, 1'b1, v, 0, 0);
        idle({tag, "_after"}, RELOAD ? v : 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        load = 1'b0; value = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_cnt", int'(cnt), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tc", int'(tc), 0);
        reset_n = 1'b1;
        idle("post_reset0", 0, 0, 0);
        idle("post_reset1", 0, 0, 0);

        // Basic run, V=5
        step("basic_load", 1'b1, 5, 1'b0, 1'b0, 1'b0, 5, 0, 0);
        step("basic_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 5, 1, 0);
        for (int j = 1; j <= 4; j++) idle("basic_dec", 5 - j, 1, 0);
        terminal("basic_term", 5);

        // Pause for 3 cycles after the first decrement, V=4
        step("pause_load", 1'b1, 4, 1'b0, 1'b0, 1'b0, 4, 0, 0);
        step("pause_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 4, 1, 0);
        idle("pause_dec3", 3, 1, 0);
        for (int j = 0; j < 3; j++) step("pause_hold", 1'b0, 0, 1'b0, 1'b1, 1'b0, 3, 1, 0);
        idle("pause_dec2", 2, 1, 0);
        idle("pause_dec1", 1, 1, 0);
        terminal("pause_term", 4);

        // Stop at cnt=2
        step("stop_load", 1'b1, 5, 1'b0, 1'b0, 1'b0, 5, 0, 0);
        step("stop_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 5, 1, 0);
        for (int j = 1; j <= 3; j++) idle("stop_dec", 5 - j, 1, 0);
        step("stop_hit", 1'b0, 0, 1'b0, 1'b0, 1'b1, 2, 0, 0);
        idle("stop_after", 2, 0, 0);

        // Load coinciding with the terminal edge
        step("ldterm_load", 1'b1, 2, 1'b0, 1'b0, 1'b0, 2, 0, 0);
        step("ldterm_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 1, 0);
        idle("ldterm_dec", 1, 1, 0);
        step("ldterm_hit", 1'b1, 9, 1'b0, 1'b0, 1'b0, 9, 0, 0);
        idle("ldterm_after", 9, 0, 0);

        // Start with cnt=0
        step("zero_load", 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step("zero_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1);
        idle("zero_after", 0, 0, 0);

        // Maximum value 15
        step("max_load", 1'b1, 15, 1'b0, 1'b0, 1'b0, 15, 0, 0);
        step("max_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 15, 1, 0);
        for (int j = 1; j <= 14; j++) idle("max_dec", 15 - j, 1, 0);
        terminal("max_term", 15);

        // Start while running is ignored
        step("rstart_load", 1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 0, 0);
        step("rstart_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 3, 1, 0);
        step("rstart_again2", 1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 1, 0);
        step("rstart_again1", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 1, 0);
        terminal("rstart_term", 3);

`ifdef DOWN_TIMER_RELOAD_EN
        // Periodic mode, R=3, four periods then stop
        step("rel_load", 1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 0, 0);
        step("rel_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 3, 1, 0);
        for (int p = 0; p < 4; p++) begin
            idle("rel_c2", 2, 1, 0);
            idle("rel_c1", 1, 1, 0);
            idle("rel_tc", 3, 1, 1);
        end
        step("rel_stop", 1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 0, 0);
        for (int j = 0; j < 3; j++) idle("rel_after", 3, 0, 0);
`endif

        // Asynchronous reset mid-run at cnt=3
        step("arst_load", 1'b1, 5, 1'b0, 1'b0, 1'b0, 5, 0, 0);
        step("arst_start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 5, 1, 0);
        idle("arst_dec4", 4, 1, 0);
        idle("arst_dec3", 3, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_cnt", int'(cnt), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_tc", int'(tc), 0);
        #1 reset_n = 1'b1;
        idle("arst_after0", 0, 0, 0);
        idle("arst_after1", 0, 0, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
